// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the memory-stage data port of the ARM32 core.
package cpu_mem_pkg;

  typedef enum logic [0:0] {
    DMEM_IDLE = 1'b0,
    DMEM_BUS  = 1'b1
  } dmem_state_t;

  localparam int         DMEM_TIMEOUT_DEFAULT = 255;
  localparam logic [1:0] WORD_ALIGN_MASK      = 2'b11;

  // Access captured at acceptance and replayed on the bus until ack.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  rd;
  } dmem_req_t;

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/data_mem_port_if.sv
// Valid/ack bus between the data-memory port (master) and the data memory (slave).
interface data_mem_port_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_watchdog.sv
// Bus-wait watchdog: loaded on entry to BUS, flags expiry after TIMEOUT bus cycles.
module dmem_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [W-1:0] cnt;

  // Loaded with TIMEOUT-1 so that the TIMEOUT-th bus cycle sees zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (load)             cnt <= W'(TIMEOUT - 1);
    else if (en && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/data_mem_port.sv
// Memory-stage LDR/STR responder: valid/ack bus handshake, pipeline stall, load return.
// Optional bus watchdog enabled by defining DMEM_TIMEOUT_EN.
module data_mem_port
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_rd,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [3:0]  ld_rd,
  output logic        err,
  data_mem_port_if.master bus
);

  localparam logic [0:0] ST_IDLE = 1'(DMEM_IDLE);
  localparam logic [0:0] ST_BUS  = 1'(DMEM_BUS);

  logic [0:0] state;
  dmem_req_t  lat;
  logic       in_bus, aligned, accept, misalign, done, expired, timeout;

  assign in_bus   = (state == ST_BUS);
  assign aligned  = word_aligned(req_addr);
  assign accept   = !in_bus && req_valid && aligned;
  assign misalign = !in_bus && req_valid && !aligned;
  assign done     = in_bus && bus.mem_ack;
  // Ack in the expiry cycle wins over the watchdog.
  assign timeout  = in_bus && expired && !bus.mem_ack;

  // Gated by rst_n so the pipeline is released the moment reset hits.
  assign stall = rst_n && (accept || (in_bus && !bus.mem_ack && !timeout));

`ifdef DMEM_TIMEOUT_EN
  dmem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .en      (in_bus),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  assign bus.mem_req   = in_bus;
  assign bus.mem_we    = lat.we;
  assign bus.mem_addr  = lat.addr;
  assign bus.mem_wdata = lat.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lat      <= '0;
      ld_valid <= 1'b0;
      ld_data  <= '0;
      ld_rd    <= '0;
      err      <= 1'b0;
    end else begin
      ld_valid <= done && !lat.we;
      err      <= misalign || timeout;
      if (accept) begin
        state <= ST_BUS;
        lat   <= '{we: req_we, addr: req_addr, wdata: req_wdata, rd: req_rd};
      end else if (done || timeout) begin
        state <= ST_IDLE;
      end
      if (done && !lat.we) begin
        ld_data <= bus.mem_rdata;
        ld_rd   <= lat.rd;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_port.sv
// Bench for data_mem_port: directed table, corner sequences and a randomized run
// against a transaction-level model; watchdog cases when DMEM_TIMEOUT_EN is defined.
module tb_data_mem_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_rd = '0;
  logic        stall, ld_valid, err;
  logic [31:0] ld_data;
  logic [3:0]  ld_rd;

  data_mem_port_if bus();

  data_mem_port #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rd    (req_rd),
    .stall     (stall),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_rd     (ld_rd),
    .err       (err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory responder: acks after ack_after wait cycles (-1 = never).
  int              ack_after = 0;
  bit              spurious  = 1'b0;
  int              waited    = 0;
  logic [31:0]     bmem [logic [31:0]];
  logic [64:0]     log_q [$];

  always @(posedge clk) begin
    #1;
    if (bus.mem_req && ack_after >= 0 && waited == ack_after) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = bmem.exists(bus.mem_addr) ? bmem[bus.mem_addr] : init_val(bus.mem_addr);
      if (bus.mem_we) bmem[bus.mem_addr] = bus.mem_wdata;
      log_q.push_back({bus.mem_we, bus.mem_addr, bus.mem_wdata});
      waited = 0;
    end else begin
      bus.mem_ack   = spurious && !bus.mem_req && ($urandom_range(0, 3) == 0);
      bus.mem_rdata = $urandom;
      waited        = bus.mem_req ? waited + 1 : 0;
    end
  end

  // Reference model state: memory contents as seen by the program, last load returned.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] hold_data = '0;
  logic [3:0]  hold_rd   = '0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  rd;
    int          waits;
    int          exp_stall;
    int          exp_req;
    bit          exp_ld;
    bit          exp_err;
    logic [31:0] exp_data;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_access(input vec_t v, input string tag);
    int nst = 0, nld = 0, nerr = 0, nreq = 0, ld_at = -1, err_at = -1, q0;
    bit bus_ok = 1'b1, prev = 1'b0;
    logic [31:0] gd = '0;
    logic [3:0]  gr = '0;
    logic [64:0] ent;
    ack_after = v.waits;
    q0 = log_q.size();
    tick();
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    #1;
    for (int c = 0; c < v.waits + 5; c++) begin
      if (c > 0) begin
        tick();
        // While the port is busy the request lines are don't-care.
        if (prev) begin
          req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_rd = 4'($urandom);
        end else req_valid = 1'b0;
        #1;
      end
      prev = stall;
      if (stall) nst++;
      if (bus.mem_req) begin
        nreq++;
        if (bus.mem_we !== v.we || bus.mem_addr !== v.addr || bus.mem_wdata !== v.wdata) bus_ok = 1'b0;
      end
      if (ld_valid) begin nld++; ld_at = c; gd = ld_data; gr = ld_rd; end
      if (err) begin nerr++; err_at = c; end
    end
    check({tag, " stall_cycles"}, 64'(nst), 64'(v.exp_stall));
    check({tag, " req_cycles"}, 64'(nreq), 64'(v.exp_req));
    check({tag, " ld_pulses"}, 64'(nld), 64'(v.exp_ld));
    check({tag, " err_pulses"}, 64'(nerr), 64'(v.exp_err));
    check({tag, " bus_stable"}, 64'(bus_ok), 64'd1);
    check({tag, " bus_txns"}, 64'(log_q.size() - q0), (v.exp_req > 0) ? 64'd1 : 64'd0);
    if (v.exp_req > 0 && log_q.size() > q0) begin
      ent = log_q[log_q.size() - 1];
      check({tag, " log_addr"}, 64'(ent[63:32]), 64'(v.addr));
      check({tag, " log_we_data"}, 64'({ent[64], ent[31:0]}), 64'({v.we, v.wdata}));
    end
    if (v.exp_ld) begin
      check({tag, " ld_at"}, 64'(ld_at), 64'(v.waits + 2));
      check({tag, " ld_data"}, 64'(gd), 64'(v.exp_data));
      check({tag, " ld_rd"}, 64'(gr), 64'(v.rd));
      hold_data = v.exp_data;
      hold_rd   = v.rd;
    end
    if (v.exp_err) check({tag, " err_at"}, 64'(err_at), 64'd1);
    check({tag, " ld_data_hold"}, 64'(ld_data), 64'(hold_data));
    check({tag, " ld_rd_hold"}, 64'(ld_rd), 64'(hold_rd));
  endtask

  initial begin
    vec_t        tbl [5];
    vec_t        v;
    int          q0, idx, nreq, nst, nerr, nld, err_at;
    logic [1:0]  lo;
    bit          aligned;

    tbl[0] = '{we:1'b0, addr:32'h100, wdata:32'h0, rd:4'd5, waits:0,
               exp_stall:1, exp_req:1, exp_ld:1'b1, exp_err:1'b0, exp_data:32'hDEADBEEF};
    tbl[1] = '{we:1'b1, addr:32'h204, wdata:32'h12345678, rd:4'd0, waits:3,
               exp_stall:4, exp_req:4, exp_ld:1'b0, exp_err:1'b0, exp_data:32'h0};
    tbl[2] = '{we:1'b0, addr:32'h102, wdata:32'h0, rd:4'd3, waits:0,
               exp_stall:0, exp_req:0, exp_ld:1'b0, exp_err:1'b1, exp_data:32'h0};
    tbl[3] = '{we:1'b0, addr:32'h204, wdata:32'h55, rd:4'd9, waits:1,
               exp_stall:2, exp_req:2, exp_ld:1'b1, exp_err:1'b0, exp_data:32'h12345678};
    tbl[4] = '{we:1'b1, addr:32'h301, wdata:32'h77, rd:4'd1, waits:0,
               exp_stall:0, exp_req:0, exp_ld:1'b0, exp_err:1'b1, exp_data:32'h0};

    bmem[32'h100]    = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;

    // Reset values
    #12;
    check("rst mem_req", 64'(bus.mem_req), 64'd0);
    check("rst mem_we", 64'(bus.mem_we), 64'd0);
    check("rst mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst stall", 64'(stall), 64'd0);
    check("rst ld_valid_err", 64'({ld_valid, err}), 64'd0);
    check("rst ld_data_rd", 64'({ld_data, ld_rd}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_access(tbl[i], $sformatf("vec%0d", i));
    ref_mem[32'h204] = 32'h12345678;

    // Back-to-back load then store, both acked in the first bus cycle.
    ack_after = 0;
    q0 = log_q.size();
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_wdata = 32'h0; req_rd = 4'd7;
    #1;
    check("b2b stall_T", 64'(stall), 64'd1);
    tick(); #1;
    check("b2b stall_ack", 64'(stall), 64'd0);
    tick();
    req_we = 1'b1; req_addr = 32'h208; req_wdata = 32'hCAFEF00D; req_rd = 4'd0;
    #1;
    check("b2b ld_valid_T2", 64'(ld_valid), 64'd1);
    check("b2b ld_data", 64'(ld_data), 64'hDEADBEEF);
    check("b2b ld_rd", 64'(ld_rd), 64'd7);
    check("b2b stall_T2", 64'(stall), 64'd1);
    tick(); #1;
    check("b2b stall_T3", 64'(stall), 64'd0);
    check("b2b ld_valid_T3", 64'(ld_valid), 64'd0);
    tick();
    req_valid = 1'b0;
    #1;
    check("b2b ld_valid_T4", 64'(ld_valid), 64'd0);
    check("b2b txns", 64'(log_q.size() - q0), 64'd2);
    if (log_q.size() - q0 == 2) begin
      check("b2b first", 64'(log_q[q0][63:32]), 64'h100);
      check("b2b second", 64'({log_q[q0+1][64], log_q[q0+1][63:32]}), {31'd0, 1'b1, 32'h208});
    end
    ref_mem[32'h208] = 32'hCAFEF00D;
    hold_data = 32'hDEADBEEF;
    hold_rd   = 4'd7;

    // Reset while a request is outstanding.
    ack_after = 20;
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_rd = 4'd2;
    #1;
    tick(); req_valid = 1'b0; #1;
    tick(); #1;
    check("rstmid mem_req_before", 64'(bus.mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid mem_req", 64'(bus.mem_req), 64'd0);
    check("rstmid stall", 64'(stall), 64'd0);
    check("rstmid ld_valid_err", 64'({ld_valid, err}), 64'd0);
    tick(); #1;
    tick();
    rst_n = 1'b1;
    #1;
    check("rstmid idle_req", 64'(bus.mem_req), 64'd0);
    check("rstmid idle_stall", 64'(stall), 64'd0);
    hold_data = '0;
    hold_rd   = '0;
    run_access(tbl[0], "post_rst");

`ifdef DMEM_TIMEOUT_EN
    // Ack never arrives: request dropped after 4 bus cycles, err follows.
    ack_after = -1;
    nreq = 0; nst = 0; nerr = 0; nld = 0; err_at = -1;
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_rd = 4'd1;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin tick(); req_valid = 1'b0; #1; end
      if (bus.mem_req) nreq++;
      if (stall) nst++;
      if (ld_valid) nld++;
      if (err) begin nerr++; err_at = c; end
    end
    check("tmo req_cycles", 64'(nreq), 64'd4);
    check("tmo stall_cycles", 64'(nst), 64'd4);
    check("tmo err_pulses", 64'(nerr), 64'd1);
    check("tmo err_at", 64'(err_at), 64'd5);
    check("tmo ld_pulses", 64'(nld), 64'd0);
    v = '{we:1'b0, addr:32'h100, wdata:32'h0, rd:4'd4, waits:3,
          exp_stall:4, exp_req:4, exp_ld:1'b1, exp_err:1'b0, exp_data:32'hDEADBEEF};
    run_access(v, "tmo_ack_wins");
`endif

    // Randomized accesses against the transaction-level model.
    spurious = 1'b1;
    repeat (40) begin
      idx  = $urandom_range(0, 15);
      lo   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      aligned = (lo == 2'b00);
      v.we      = 1'($urandom);
      v.addr    = 32'h1000 + 32'(idx * 4) + 32'(lo);
      v.wdata   = $urandom;
      v.rd      = 4'($urandom);
      v.waits   = $urandom_range(0, 3);
      v.exp_stall = aligned ? v.waits + 1 : 0;
      v.exp_req   = v.exp_stall;
      v.exp_err   = !aligned;
      v.exp_ld    = aligned && !v.we;
      v.exp_data  = ref_mem.exists(v.addr) ? ref_mem[v.addr] : init_val(v.addr);
      if (aligned && v.we) ref_mem[v.addr] = v.wdata;
      run_access(v, "rand");
    end
    spurious = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
